dcache_port_arbiter: RTL
========================

Name: dcache_port_arbiter

Overview:
- Shares the single HPDCACHE request port between NrPorts core-side requesters: load unit, store unit and CV-X-IF coprocessor memory path.
- Arbitrates round-robin and registers the winning request into a one-deep output stage.
- Tags each in-flight transaction with an internal slot ID, bounded by MaxOutstanding.
- Routes each response back to its originating requester and restores that requester's own transaction ID.

Parameters:
- NrPorts, 3, number of requesters (≥2).
- AddrWidth, 32, request address width (XLEN).
- DataWidth, 32, write/read data width.
- TidWidth, 4, transaction ID width on both sides (MemTidWidth).
- MaxOutstanding, 7, in-flight slot count; $clog2(MaxOutstanding) ≤ TidWidth (elaboration check).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NrPorts  per-requester request valid.
- req_ready_o  out  NrPorts  per-requester accept.
- req_addr_i  in  NrPorts*AddrWidth  request address.
- req_we_i  in  NrPorts  write enable.
- req_wdata_i  in  NrPorts*DataWidth  write data.
- req_be_i  in  NrPorts*DataWidth/8  byte enables.
- req_tid_i  in  NrPorts*TidWidth  requester-local transaction ID.
- mem_req_valid_o  out  1  downstream request valid.
- mem_req_ready_i  in  1  downstream accept.
- mem_req_addr_o  out  AddrWidth  downstream address.
- mem_req_we_o  out  1  downstream write enable.
- mem_req_wdata_o  out  DataWidth  downstream write data.
- mem_req_be_o  out  DataWidth/8  downstream byte enables.
- mem_req_tid_o  out  TidWidth  internal slot index.
- mem_rsp_valid_i  in  1  downstream response valid (no back-pressure).
- mem_rsp_tid_i  in  TidWidth  slot index of the response.
- mem_rsp_rdata_i  in  DataWidth  response data.
- rsp_valid_o  out  NrPorts  per-requester response valid (one-hot or zero).
- rsp_tid_o  out  TidWidth  restored requester ID.
- rsp_rdata_o  out  DataWidth  response data, shared by all requesters.
- outstanding_o  out  $clog2(MaxOutstanding+1)  occupied slot count.
- idle_o  out  1  no slot occupied and output stage empty.
- err_o  out  1  sticky: response arrived for a free slot.

Behaviour:
- Reset values:
  - mem_req_valid_o=0, outstanding_o=0, idle_o=1, err_o=0, rsp_valid_o=0, req_ready_o=0.
  - RR pointer=0; all slots free.
  - Data outputs are 0.
- Arbitration:
  - Round-robin over req_valid_i, starting at the pointer.
  - Pointer moves to winner+1 (mod NrPorts) only on an accepted grant; unaccepted grants leave it unchanged.
- Accept condition: req_ready_o[w]=1 only for the winner w, and only when a free slot exists AND (mem_req_valid_o==0 OR mem_req_ready_i==1).
- Requester protocol: must hold valid and payload stable until ready; a bench assertion checks this.
- Slot allocation: the lowest free slot is allocated on accept. It stores {port, req_tid}, and its index drives mem_req_tid_o.
- Output stage:
  - Loads on accept, so latency is 1 cycle from accept to mem_req_valid_o.
  - Holds while mem_req_ready_i=0.
  - Back-to-back throughput is 1 request/cycle.
- Response path (combinational, 0-cycle):
  - On mem_rsp_valid_i with an occupied slot: rsp_valid_o[slot.port]=1, rsp_tid_o=slot.tid, rsp_rdata_o=mem_rsp_rdata_i.
  - The slot is freed at the clock edge.
  - Writes also receive a response.
- Simultaneous free and allocate: a slot freed in cycle N is allocatable from cycle N+1 only. Free and allocate in the same cycle leave outstanding_o unchanged.
- Full: when outstanding_o==MaxOutstanding, all req_ready_o=0. The output stage still drains.
- Invalid response (free slot or index ≥ MaxOutstanding): dropped, rsp_valid_o stays 0, err_o set until reset.
- Reset mid-operation: all slots and the output stage clear immediately. In-flight downstream responses after reset are treated as invalid and set err_o; the integration must not release reset with transactions in flight.

Decomposition:
- Shared package dcache_arb_pkg holds:
  - slot_entry_t {port index, tid};
  - arb_req_t {addr, we, wdata, be, tid};
  - the SlotIdxWidth function.
- One sub-module: rr_arbiter (request vector, advance enable → one-hot grant plus index). It is reused for any future port sharing.
- Lowest-free-slot select stays inline as a priority encoder.

Test Plan:
- Reset then idle: hold rst_ni=0 for 3 cycles, no requests → all outputs at reset values, idle_o=1.
- Fairness: all 3 ports request continuously with mem_req_ready_i=1 and responses returned after 2 cycles → grants follow 0,1,2,0,1,2; mem_req_tid_o cycles through slots.
- Full back-pressure: 7 accepts with no responses → outstanding_o=7 and req_ready_o=0. Inject a response on slot 3 → in the next cycle a grant takes slot 3.
- Response routing: port 1 issues tid=0xA, port 2 issues tid=0x5; responses come back in reverse order → rsp_valid_o=3'b100 with tid 0x5, then 3'b010 with tid 0xA, data matching.
- Stall: mem_req_ready_i=0 for 4 cycles → mem_req_valid_o and payload stable, req_ready_o=0, pointer not advanced.
- Error: response with tid=6 while slot 6 is free → no rsp_valid_o, err_o=1 sticky until rst_ni low.

Source files
------------

// File: rtl/dcache_arb_pkg.sv
// Shared types and helpers for the data-cache request port arbiter.
// Struct widths are fixed here; the top module checks its parameters against them.
package dcache_arb_pkg;

  localparam int unsigned ArbAddrWidth = 32;
  localparam int unsigned ArbDataWidth = 32;
  localparam int unsigned ArbTidWidth  = 4;
  localparam int unsigned ArbPortWidth = 4;

  typedef struct packed {
    logic [ArbPortWidth-1:0] port;
    logic [ArbTidWidth-1:0]  tid;
  } slot_entry_t;

  typedef struct packed {
    logic [ArbAddrWidth-1:0]   addr;
    logic                      we;
    logic [ArbDataWidth-1:0]   wdata;
    logic [ArbDataWidth/8-1:0] be;
    logic [ArbTidWidth-1:0]    tid;
  } arb_req_t;

  function automatic int unsigned SlotIdxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer; the pointer moves past the
// winner only when the caller signals that the grant was taken.
module rr_arbiter
  import dcache_arb_pkg::*;
#(
  parameter  int unsigned N    = 3,
  localparam int unsigned IdxW = SlotIdxWidth(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IdxW'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (idx == IdxW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one HPDCACHE request port between NrPorts requesters, tagging each
// request with a slot index and routing responses back to the originator.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NrPorts        = 3,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned TidWidth       = 4,
  parameter int unsigned MaxOutstanding = 7
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NrPorts-1:0]                   req_valid_i,
  output logic [NrPorts-1:0]                   req_ready_o,
  input  logic [NrPorts*AddrWidth-1:0]         req_addr_i,
  input  logic [NrPorts-1:0]                   req_we_i,
  input  logic [NrPorts*DataWidth-1:0]         req_wdata_i,
  input  logic [NrPorts*DataWidth/8-1:0]       req_be_i,
  input  logic [NrPorts*TidWidth-1:0]          req_tid_i,
  output logic                                 mem_req_valid_o,
  input  logic                                 mem_req_ready_i,
  output logic [AddrWidth-1:0]                 mem_req_addr_o,
  output logic                                 mem_req_we_o,
  output logic [DataWidth-1:0]                 mem_req_wdata_o,
  output logic [DataWidth/8-1:0]               mem_req_be_o,
  output logic [TidWidth-1:0]                  mem_req_tid_o,
  input  logic                                 mem_rsp_valid_i,
  input  logic [TidWidth-1:0]                  mem_rsp_tid_i,
  input  logic [DataWidth-1:0]                 mem_rsp_rdata_i,
  output logic [NrPorts-1:0]                   rsp_valid_o,
  output logic [TidWidth-1:0]                  rsp_tid_o,
  output logic [DataWidth-1:0]                 rsp_rdata_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 idle_o,
  output logic                                 err_o
);

  localparam int unsigned PortW = SlotIdxWidth(NrPorts);
  localparam int unsigned SlotW = SlotIdxWidth(MaxOutstanding);
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeW   = DataWidth / 8;

  if (AddrWidth != ArbAddrWidth || DataWidth != ArbDataWidth || TidWidth != ArbTidWidth) begin : g_bad_width
    $error("dcache_port_arbiter: widths must match dcache_arb_pkg");
  end
  if (NrPorts < 2 || PortW > ArbPortWidth) begin : g_bad_ports
    $error("dcache_port_arbiter: unsupported NrPorts");
  end
  if ($clog2(MaxOutstanding) > TidWidth) begin : g_bad_slots
    $error("dcache_port_arbiter: MaxOutstanding does not fit in TidWidth");
  end

  logic [NrPorts-1:0]        grant;
  logic [PortW-1:0]          win_idx;
  logic                      any_free;
  logic                      can_accept;
  logic                      accept;
  logic [SlotW-1:0]          free_idx;
  logic [MaxOutstanding-1:0] slot_valid;
  slot_entry_t               slot_entry [MaxOutstanding];
  slot_entry_t               new_entry;
  arb_req_t                  win_req;
  arb_req_t                  out_q;
  logic                      out_valid;
  logic                      rsp_hit;
  logic [SlotW-1:0]          rsp_idx;
  slot_entry_t               rsp_entry;
  logic [CntW-1:0]           count;
  logic                      err_q;

  rr_arbiter #(.N(NrPorts)) u_rr (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .req     (req_valid_i),
    .advance (accept),
    .grant   (grant),
    .idx     (win_idx)
  );

  // Lowest free slot; scanning downward lets the lowest index win.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    count    = '0;
    for (int unsigned i = MaxOutstanding; i > 0; i--) begin
      if (!slot_valid[i-1]) begin
        any_free = 1'b1;
        free_idx = SlotW'(i - 1);
      end
      count = count + CntW'(slot_valid[i-1]);
    end
  end

  assign can_accept  = any_free && (!out_valid || mem_req_ready_i);
  assign accept      = can_accept && (|req_valid_i);
  assign req_ready_o = can_accept ? grant : '0;

  always_comb begin
    win_req.addr   = req_addr_i[32'(win_idx)*AddrWidth +: AddrWidth];
    win_req.we     = req_we_i[win_idx];
    win_req.wdata  = req_wdata_i[32'(win_idx)*DataWidth +: DataWidth];
    win_req.be     = req_be_i[32'(win_idx)*BeW +: BeW];
    win_req.tid    = TidWidth'(free_idx);
    new_entry.port = ArbPortWidth'(win_idx);
    new_entry.tid  = req_tid_i[32'(win_idx)*TidWidth +: TidWidth];
  end

  always_comb begin
    rsp_hit   = 1'b0;
    rsp_idx   = '0;
    rsp_entry = '0;
    for (int unsigned i = 0; i < MaxOutstanding; i++) begin
      if (mem_rsp_valid_i && mem_rsp_tid_i == TidWidth'(i) && slot_valid[i]) begin
        rsp_hit   = 1'b1;
        rsp_idx   = SlotW'(i);
        rsp_entry = slot_entry[i];
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      rsp_valid_o[p] = rsp_hit && (rsp_entry.port == ArbPortWidth'(p));
    end
  end

  assign rsp_tid_o   = rsp_entry.tid;
  assign rsp_rdata_o = rsp_hit ? mem_rsp_rdata_i : '0;

  // Free and allocate never target the same slot: allocation only sees
  // slots that were already free before this edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        slot_entry[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        if (rsp_hit && rsp_idx == SlotW'(i)) begin
          slot_valid[i] <= 1'b0;
        end
        if (accept && free_idx == SlotW'(i)) begin
          slot_valid[i] <= 1'b1;
          slot_entry[i] <= new_entry;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_q     <= win_req;
      end else if (mem_req_ready_i) begin
        out_valid <= 1'b0;
      end
      if (mem_rsp_valid_i && !rsp_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_req_valid_o = out_valid;
  assign mem_req_addr_o  = out_q.addr;
  assign mem_req_we_o    = out_q.we;
  assign mem_req_wdata_o = out_q.wdata;
  assign mem_req_be_o    = out_q.be;
  assign mem_req_tid_o   = out_q.tid;
  assign outstanding_o   = count;
  assign idle_o          = (slot_valid == '0) && !out_valid;
  assign err_o           = err_q;

endmodule
